// File: rtl/gcd_lcm_engine.sv
// gcd_lcm_engine: sequential GCD/LCM engine (binary Stein GCD, restoring divide, single multiply)
// with valid/ready handshakes on both operand and result sides.
module gcd_lcm_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     gcd,
    output logic [2*DATA_WIDTH-1:0]   lcm,
    output logic                      zero_flag,
    output logic                      busy
);
    localparam int W  = DATA_WIDTH;
    localparam int LW = 2 * DATA_WIDTH;
    localparam int KW = $clog2(W + 1);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, g_q, g_d, quo_q, quo_d, gcd_q, gcd_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      rem_q, rem_d;
    logic [LW-1:0]   lcm_q, lcm_d;
    logic            zf_q, zf_d;

    logic [W-1:0]    g_now, div_g, div_quo_src, div_quo;
    logic [W:0]      div_rem_src, div_t, div_rem;
    logic            div_ge;

    // The first restoring step shares the final GCD cycle, so the result lands at T0+G+W+1.
    assign g_now       = W'(x_q << k_q);
    assign div_g       = (state_q == S_GCD) ? g_now : g_q;
    assign div_rem_src = (state_q == S_GCD) ? '0 : rem_q;
    assign div_quo_src = (state_q == S_GCD) ? b_q : quo_q;
    assign div_t       = (W+1)'({div_rem_src, div_quo_src[W-1]});
    assign div_ge      = div_t >= {1'b0, div_g};
    assign div_rem     = div_ge ? div_t - {1'b0, div_g} : div_t;
    assign div_quo     = {div_quo_src[W-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        g_d     = g_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        gcd_d   = gcd_q;
        lcm_d   = lcm_q;
        zf_d    = zf_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                a_d = a;
                b_d = b;
                if (a == '0 || b == '0) begin
                    gcd_d   = a | b;
                    lcm_d   = '0;
                    zf_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    x_d     = a;
                    y_d     = b;
                    k_d     = '0;
                    state_d = S_GCD;
                end
            end
            S_GCD: begin
                if (x_q == y_q) begin
                    g_d     = g_now;
                    rem_d   = div_rem;
                    quo_d   = div_quo;
                    cnt_d   = CW'(1);
                    state_d = S_DIV;
                end else if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!x_q[0]) x_d = x_q >> 1;
                else if (!y_q[0])     y_d = y_q >> 1;
                else if (x_q > y_q)   x_d = (x_q - y_q) >> 1;
                else                  y_d = (y_q - x_q) >> 1;
            end
            S_DIV: begin
                rem_d   = div_rem;
                quo_d   = div_quo;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(W - 1)) ? S_MUL : S_DIV;
            end
            S_MUL: begin
                gcd_d   = g_q;
                lcm_d   = LW'(a_q) * LW'(quo_q);
                zf_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            g_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            gcd_q   <= '0;
            lcm_q   <= '0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            g_q     <= g_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            gcd_q   <= gcd_d;
            lcm_q   <= lcm_d;
            zf_q    <= zf_d;
        end
    end

    assign in_ready  = state_q == S_IDLE;
    assign busy      = state_q != S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign gcd       = gcd_q;
    assign lcm       = lcm_q;
    assign zero_flag = zf_q;
endmodule

// File: tb/tb_gcd_lcm_engine.sv
// tb_gcd_lcm_engine: directed corner cases plus a randomized sweep with stalls,
// compared against an arithmetic GCD/LCM reference and a Stein step-count latency model.
module tb_gcd_lcm_engine;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready, out_valid, zero_flag, busy;
    logic [W-1:0]   gcd;
    logic [2*W-1:0] lcm;

    int checks = 0;
    int errors = 0;

    gcd_lcm_engine #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .gcd(gcd), .lcm(lcm), .zero_flag(zero_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_gcd(input longint x, input longint y);
        longint t;
        if (x == 0 || y == 0) return x | y;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of Stein iterations up to and including the x==y cycle.
    function automatic int stein_steps(input int x, input int y);
        int n = 1;
        while (x != y) begin
            if (x % 2 == 0 && y % 2 == 0) begin
                x = x / 2;
                y = y / 2;
            end else if (x % 2 == 0) x = x / 2;
            else if (y % 2 == 0)     y = y / 2;
            else if (x > y)          x = (x - y) / 2;
            else                     y = (y - x) / 2;
            n++;
        end
        return n;
    endfunction

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input int stall);
        logic [W-1:0]   eg;
        logic [2*W-1:0] el;
        logic           ez;
        int             elat, lat;
        ez   = (av == 0 || bv == 0);
        eg   = W'(ref_gcd(longint'(av), longint'(bv)));
        el   = ez ? '0 : (2*W)'(longint'(av) * longint'(bv) / longint'(eg));
        elat = ez ? 1 : stein_steps(int'(av), int'(bv)) + W + 1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat <= 4 * W + 8) begin
            check("ready_vs_busy", in_ready, !busy);
            a = W'($urandom);
            b = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 lat++;
        end
        check("latency", lat, elat);
        check("done_busy", busy, 1);
        check("done_in_ready", in_ready, 0);
        check("gcd", gcd, eg);
        check("lcm", lcm, el);
        check("zero_flag", zero_flag, ez);
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk);
                #1;
                check("hold_valid", out_valid, 1);
                check("hold_gcd", gcd, eg);
                check("hold_lcm", lcm, el);
                check("hold_in_ready", in_ready, 0);
                a = W'($urandom);
                b = W'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_gcd_kept", gcd, eg);
        check("post_lcm_kept", lcm, el);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_gcd", gcd, 0);
        check("rst_lcm", lcm, 0);
        check("rst_zero_flag", zero_flag, 0);
        @(negedge clk) rst_n = 1'b1;

        run(8'd12, 8'd18, 0);
        run(8'd255, 8'd254, 0);
        run(8'd128, 8'd128, 0);
        run(8'd0, 8'd7, 0);
        run(8'd0, 8'd0, 0);
        run(8'd21, 8'd6, 5);

        @(negedge clk);
        a = 8'd100;
        b = 8'd75;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (stein_steps(100, 75) + 3) @(posedge clk);
        #1;
        check("mid_div_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_gcd", gcd, 0);
        check("abort_lcm", lcm, 0);
        check("abort_zero_flag", zero_flag, 0);
        @(negedge clk) rst_n = 1'b1;
        run(8'd9, 8'd6, 0);

        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            run(ra, rb, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_lcm_engine.md
# gcd_lcm_engine

Parametrised, fully sequential GCD/LCM engine with valid/ready handshakes on both sides. It replaces the edge-triggered, combinational-divider GCD/LCM block. Operands are computed with Stein's binary GCD, then LCM = a·(b/gcd) is formed with a W-cycle restoring divider and one multiply cycle. It sits between an operand producer and a result consumer, and either side may stall.

## Interface
- DATA_WIDTH, default 8, operand width W (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair a/b valid
- in_ready  out  1  engine can accept operands (high only in IDLE)
- a  in  W  first operand, unsigned
- b  in  W  second operand, unsigned
- out_valid  out  1  gcd/lcm/zero_flag valid; held until accepted
- out_ready  in  1  consumer accepts result
- gcd  out  W  greatest common divisor
- lcm  out  2W  least common multiple
- zero_flag  out  1  at least one operand was 0
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, GCD, DIV, MUL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a_r=a and b_r=b. If either is 0, go to DONE directly; otherwise load x=a, y=b, k=0 and go to GCD.
- GCD performs one Stein step per cycle, in priority order:
  - x==y: g = x<<k, go to DIV.
  - x,y both even: x>>=1, y>>=1, k++.
  - x even: x>>=1.
  - y even: y>>=1.
  - both odd, x>y: x=(x-y)>>1.
  - both odd, otherwise: y=(y-x)>>1.
- k needs ceil(log2(W+1)) bits. g never exceeds W bits.
- DIV: restoring division of b_r by g, exactly W cycles, MSB first. A counter of ceil(log2 W) bits drives the steps; remainder is W+1 bits and quotient q is W bits. The remainder is always 0 at the end (exact division). Go to MUL.
- MUL: one cycle, lcm_r = a_r·q at 2W bits. a_r·q ≤ a·b < 2^(2W), so no overflow. Go to DONE.
- DONE: out_valid=1 and outputs are stable. On out_valid&&out_ready, go to IDLE.
- Zero path: gcd = a_r|b_r (the nonzero operand, or 0 if both are 0), lcm = 0, zero_flag = 1.
- Result registers gcd/lcm/zero_flag update only on entry to DONE. They keep their value after the handshake until the next result.
- Operands are not re-sampled while busy. Changes on a/b outside IDLE are ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, gcd=0, lcm=0, zero_flag=0, state=IDLE, all datapath registers 0.
- Accept edge T0 (in_valid&&in_ready sampled high). busy=1 and in_ready=0 from T0+1.
- Nonzero latency: out_valid rises at T0 + G + W + 1, where G is the number of GCD cycles, including the final x==y cycle.
- Zero latency: out_valid rises at T0+1.
- Bound: G ≤ 2W+1.
- out_ready low in DONE: out_valid stays high and gcd/lcm/zero_flag stay constant (no drop, no change).
- Accept edge in DONE: out_valid=0 and in_ready=1 at the next cycle. Back-to-back throughput therefore has at least 1 IDLE cycle between results. No operand is accepted in the same cycle a result is consumed.
- out_ready high outside DONE: ignored.
- Reset asserted mid-operation: all state clears immediately to the reset values. No result is produced for the aborted pair.
- Inputs are synchronous to clk. rst_n deassertion is synchronised externally.

## Test plan
- W=8, a=12, b=18, out_ready=1 -> gcd=6, lcm=36, zero_flag=0. G=4, so out_valid at T0+13, high for exactly 1 cycle.
- W=8, a=255, b=254 -> gcd=1, lcm=64770. a=128, b=128 -> gcd=128, lcm=128 (x==y on first GCD cycle, latency 1+8+1=10).
- Zero operands: a=0, b=7 -> gcd=7, lcm=0, zero_flag=1, out_valid at T0+1. a=0, b=0 -> gcd=0, lcm=0, zero_flag=1.
- Backpressure: a=21, b=6 with out_ready held low 5 cycles after out_valid. Outputs must be stable (gcd=3, lcm=42), in_ready=0, and a/b toggled meanwhile must be ignored. Release -> IDLE next cycle.
- Reset mid-DIV: assert rst_n low during DIV of a=100, b=75 -> all outputs at reset values. A new pair a=9, b=6 afterwards -> gcd=3, lcm=18.
- Random sweep, W=8 and W=16, 10k pairs, with random in_valid/out_ready stalls -> compare against a reference model. Check latency = G+W+1 and in_ready == !busy every cycle.
